// File: rtl/sc_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// sc_buffer_ctrl
//   Single-clock controller for a one-hot-addressed data buffer. It round-robin
//   arbitrates N_REQ valid/ready writers onto the buffer write port. It keeps
//   rotating one-hot write and read pointers and tracks occupancy. It presents
//   the buffer head as a valid/ready output stream.
//
// Ports
//   clk                clock, all logic on the rising edge
//   rst                synchronous active-high reset
//   req_valid/data     per-requester write request; requester i at
//                      req_data[i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready          one-hot (or zero) accept strobe
//   buf_write_*        one-hot slot, strobe and data towards the buffer
//   buf_read_pointer   one-hot head slot; buffer answers on buf_read_data
//   out_valid/data     head entry stream; out_ready pops it
//   full/empty/count   occupancy status
// -----------------------------------------------------------------------------
module sc_buffer_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int N_REQ        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]       req_data,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [BUFFER_DEPTH-1:0]           buf_write_pointer,
  output logic                              buf_write_enable,
  output logic [DATA_WIDTH-1:0]             buf_write_data,
  output logic [BUFFER_DEPTH-1:0]           buf_read_pointer,
  input  logic [DATA_WIDTH-1:0]             buf_read_data,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  input  logic                              out_ready,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(BUFFER_DEPTH):0]     count
);

  localparam int CW = $clog2(BUFFER_DEPTH) + 1;
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [BUFFER_DEPTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [BUFFER_DEPTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]           count_reg, count_next;
  logic [GW-1:0]           last_grant_reg, last_grant_next;

  logic [DATA_WIDTH-1:0]   req_data_arr [N_REQ];
  logic [N_REQ-1:0]        grant_vec;
  logic [GW-1:0]           grant_idx;
  logic                    grant_found;
  logic                    push;
  logic                    pop;

  // Unpack the flat request bus into one word per requester.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant_reg) + k) % N_REQ;
      if (!grant_found && req_valid[GW'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = GW'(idx);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant_vec[gi] = grant_found && (grant_idx == GW'(gi));
    end
  endgenerate

  assign full  = (count_reg == CW'(BUFFER_DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Accept strobes depend only on fullness, never on out_ready. Both sides
  // are held quiet while reset is asserted, because the registers are still
  // clearing during that cycle.
  assign req_ready        = grant_vec & {N_REQ{~full & ~rst}};
  assign push             = |(req_valid & req_ready);
  assign buf_write_enable = push;
  assign buf_write_data   = req_data_arr[grant_idx];

  assign out_valid = ~empty & ~rst;
  assign out_data  = buf_read_data;
  assign pop       = out_valid & out_ready;

  assign buf_write_pointer = wr_ptr_reg;
  assign buf_read_pointer  = rd_ptr_reg;

  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    count_next      = count_reg;
    last_grant_next = last_grant_reg;
    if (push) begin
      wr_ptr_next     = {wr_ptr_reg[BUFFER_DEPTH-2:0], wr_ptr_reg[BUFFER_DEPTH-1]};
      last_grant_next = grant_idx;
    end
    if (pop) begin
      rd_ptr_next = {rd_ptr_reg[BUFFER_DEPTH-2:0], rd_ptr_reg[BUFFER_DEPTH-1]};
    end
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= BUFFER_DEPTH'(1);
      rd_ptr_reg     <= BUFFER_DEPTH'(1);
      count_reg      <= '0;
      // Parking on the highest index makes requester 0 the first winner.
      last_grant_reg <= GW'(N_REQ - 1);
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      last_grant_reg <= last_grant_next;
    end
  end

endmodule

// File: tb/tb_sc_buffer_ctrl.sv
module tb_sc_buffer_ctrl;

  localparam int DW = 32;
  localparam int D  = 8;
  localparam int N  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [D-1:0]    buf_write_pointer;
  logic            buf_write_enable;
  logic [DW-1:0]   buf_write_data;
  logic [D-1:0]    buf_read_pointer;
  logic [DW-1:0]   buf_read_data;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic            full;
  logic            empty;
  logic [3:0]      count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_buffer_ctrl #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .buf_write_pointer(buf_write_pointer),
    .buf_write_enable(buf_write_enable), .buf_write_data(buf_write_data),
    .buf_read_pointer(buf_read_pointer), .buf_read_data(buf_read_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .full(full), .empty(empty), .count(count)
  );

  // Behavioural stand-in for the one-hot-addressed data buffer.
  logic [DW-1:0] mem [D];

  function automatic int oh2idx(input logic [D-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < D; i++) if (oh[i]) r = i;
    return r;
  endfunction

  always @(posedge clk) begin
    if (buf_write_enable) mem[oh2idx(buf_write_pointer)] <= buf_write_data;
  end
  assign buf_read_data = mem[oh2idx(buf_read_pointer)];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic push_n(input int n, input logic [DW-1:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      req_valid = 2'b01;
      req_data[DW-1:0] = base + DW'(i);
      tick();
    end
    req_valid = 2'b00;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b01;
    req_data  = '0;
    out_ready = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_wen", buf_write_enable, 1'b0);
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_wptr", buf_write_pointer, 8'h01);
    check("rst_rptr", buf_read_pointer, 8'h01);

    // 1: fill with A..H from requester 0
    for (int i = 0; i < 8; i++) begin
      req_valid = 2'b01;
      req_data[DW-1:0] = 32'hA0 + i;
      #1;
      check($sformatf("t1_ready%0d", i), req_ready, 2'b01);
      check($sformatf("t1_wdata%0d", i), buf_write_data, 32'hA0 + i);
      check($sformatf("t1_wptr%0d", i), buf_write_pointer, 8'h01 << i);
      tick();
    end
    check("t1_full", full, 1'b1);
    check("t1_count", count, 8);
    check("t1_wptr_wrap", buf_write_pointer, 8'h01);
    check("t1_ready_full", req_ready, 2'b00);
    check("t1_wen_full", buf_write_enable, 1'b0);

    // 2: drain in order
    req_valid = 2'b00;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("t2_valid%0d", i), out_valid, 1'b1);
      check($sformatf("t2_data%0d", i), out_data, 32'hA0 + i);
      check($sformatf("t2_rptr%0d", i), buf_read_pointer, 8'h01 << i);
      tick();
    end
    check("t2_empty", empty, 1'b1);
    check("t2_count", count, 0);
    check("t2_rptr_wrap", buf_read_pointer, 8'h01);
    check("t2_out_valid", out_valid, 1'b0);

    // 3: both requesters valid, alternating grants from requester 0
    do_reset();
    out_ready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      req_data = {32'h200 + i, 32'h100 + i};
      #1;
      check($sformatf("t3_grant%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("t3_wdata%0d", i), buf_write_data,
            (i % 2 == 0) ? 32'h100 + i : 32'h200 + i);
      if (i > 0)
        check($sformatf("t3_head%0d", i), out_data,
              (i % 2 == 1) ? 32'h100 + i - 1 : 32'h200 + i - 1);
      tick();
      check($sformatf("t3_count%0d", i), count, 1);
    end
    req_valid = 2'b00;

    // 4: simultaneous push and pop at count 4
    do_reset();
    push_n(4, 32'h40);
    check("t4_count_pre", count, 4);
    req_valid = 2'b01;
    req_data[DW-1:0] = 32'h44;
    out_ready = 1'b1;
    tick();
    req_valid = 2'b00;
    out_ready = 1'b0;
    #1;
    check("t4_count", count, 4);
    check("t4_wptr", buf_write_pointer, 8'h20);
    check("t4_rptr", buf_read_pointer, 8'h02);
    check("t4_head", out_data, 32'h41);

    // 5: one-cycle latency, no bypass
    do_reset();
    req_valid = 2'b01;
    req_data[DW-1:0] = 32'hDEAD;
    #1;
    check("t5_valid_before", out_valid, 1'b0);
    tick();
    req_valid = 2'b00;
    #1;
    check("t5_valid_after", out_valid, 1'b1);
    check("t5_data_after", out_data, 32'hDEAD);

    // 6: reset mid-operation
    do_reset();
    push_n(5, 32'h50);
    check("t6_count_pre", count, 5);
    rst = 1'b1;
    req_valid = 2'b01;
    req_data[DW-1:0] = 32'hBEEF;
    out_ready = 1'b1;
    #1;
    check("t6_ready_rst", req_ready, 2'b00);
    check("t6_wen_rst", buf_write_enable, 1'b0);
    check("t6_valid_rst", out_valid, 1'b0);
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    out_ready = 1'b0;
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1'b1);
    check("t6_wptr", buf_write_pointer, 8'h01);
    check("t6_rptr", buf_read_pointer, 8'h01);
    req_valid = 2'b01;
    req_data[DW-1:0] = 32'h600D;
    #1;
    check("t6_slot0", buf_write_pointer, 8'h01);
    tick();
    req_valid = 2'b00;
    #1;
    check("t6_head", out_data, 32'h600D);
    check("t6_count_post", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
